// File: rtl/uplink_packet_arbiter.sv
// Packet-granular two-source arbiter for the 32-bit eth -> cs20 HS uplink stream.
// Optional build macro UPLINK_ARB_STRICT_PRIO_EN: s0 always wins in IDLE instead of round-robin.
`timescale 1ns/1ps

module uplink_packet_arbiter #(
    parameter int DATA_W        = 32,
    parameter int MAX_PKT_WORDS = 1024,
    parameter int STALL_TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s0_valid,
    input  logic              s0_last,
    output logic              s0_ready,
    input  logic [DATA_W-1:0] s1_data,
    input  logic              s1_valid,
    input  logic              s1_last,
    output logic              s1_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic [1:0]        o_owner,
    output logic              o_trunc,
    output logic              o_timeout
);

    localparam int WCNT_W = $clog2(MAX_PKT_WORDS + 1);
    localparam int SCNT_W = $clog2(STALL_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, GRANT0, GRANT1, DRAIN0, DRAIN1} state_t;

    state_t              state;
    logic [WCNT_W-1:0]   word_cnt;
    logic [SCNT_W-1:0]   stall_cnt;
    logic [1:0]          rst_sync;
    logic                rst_n;

    // Assertion is immediate; release reaches the core two clocks later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic              sel_s1, granted, out_free, accept, at_limit, stall_hit, pick_s1;
    logic [DATA_W-1:0] in_data;
    logic              in_valid, in_last;

    assign sel_s1    = (state == GRANT1) || (state == DRAIN1);
    assign granted   = (state == GRANT0) || (state == GRANT1);
    assign in_data   = sel_s1 ? s1_data  : s0_data;
    assign in_valid  = sel_s1 ? s1_valid : s0_valid;
    assign in_last   = sel_s1 ? s1_last  : s0_last;
    assign out_free  = !m_valid || m_ready;
    assign accept    = granted && in_valid && out_free;
    assign at_limit  = (word_cnt  == WCNT_W'(MAX_PKT_WORDS - 1));
    assign stall_hit = (stall_cnt == SCNT_W'(STALL_TIMEOUT - 1));

    assign s0_ready = ((state == GRANT0) && out_free) || (state == DRAIN0);
    assign s1_ready = ((state == GRANT1) && out_free) || (state == DRAIN1);

`ifdef UPLINK_ARB_STRICT_PRIO_EN
    assign pick_s1 = !s0_valid;
`else
    logic prefer_s1;
    assign pick_s1 = s1_valid && (!s0_valid || prefer_s1);
`endif

    // NOTE: default assignment first so every path drives o_owner and no latch is inferred.
    always_comb begin
        o_owner = 2'b00;
        case (state)
            GRANT0, DRAIN0: o_owner = 2'b01;
            GRANT1, DRAIN1: o_owner = 2'b10;
            default:        o_owner = 2'b00;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word_cnt  <= '0;
            stall_cnt <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            o_trunc   <= 1'b0;
            o_timeout <= 1'b0;
`ifndef UPLINK_ARB_STRICT_PRIO_EN
            prefer_s1 <= 1'b0;
`endif
        end else begin
            o_trunc   <= 1'b0;
            o_timeout <= 1'b0;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    word_cnt  <= '0;
                    stall_cnt <= '0;
                    if (s0_valid || s1_valid) begin
                        state <= pick_s1 ? GRANT1 : GRANT0;
`ifndef UPLINK_ARB_STRICT_PRIO_EN
                        prefer_s1 <= !pick_s1;
`endif
                    end
                end
                GRANT0, GRANT1: begin
                    if (in_valid) begin
                        stall_cnt <= '0;
                        if (accept) begin
                            m_data   <= in_data;
                            m_valid  <= 1'b1;
                            m_last   <= in_last || at_limit;
                            word_cnt <= word_cnt + 1'b1;
                            if (in_last) begin
                                state <= IDLE;
                            end else if (at_limit) begin
                                o_trunc <= 1'b1;
                                state   <= sel_s1 ? DRAIN1 : DRAIN0;
                            end
                        end
                    end else if (stall_hit) begin
                        // Packet leaves without last; the downstream framer drops it.
                        o_timeout <= 1'b1;
                        stall_cnt <= '0;
                        state     <= sel_s1 ? DRAIN1 : DRAIN0;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                DRAIN0, DRAIN1: begin
                    if (in_valid && in_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uplink_packet_arbiter.sv
// Directed bench for uplink_packet_arbiter: cycle table for single packets and back-pressure,
// plus sequences for round-robin, truncation, stall abort, valid-wins and mid-packet reset.
`timescale 1ns/1ps

module tb_uplink_packet_arbiter;

    localparam int DW   = 32;
    localparam int MAXW = 8;
    localparam int STO  = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] s0_data, s1_data, m_data;
    logic          s0_valid, s0_last, s0_ready;
    logic          s1_valid, s1_last, s1_ready;
    logic          m_valid, m_last, m_ready;
    logic [1:0]    o_owner;
    logic          o_trunc, o_timeout;

    uplink_packet_arbiter #(.DATA_W(DW), .MAX_PKT_WORDS(MAXW), .STALL_TIMEOUT(STO)) dut (
        .clk(clk), .reset_n(reset_n),
        .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
        .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .o_owner(o_owner), .o_trunc(o_trunc), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [DW:0] mon_q[$];
    logic [DW:0] exp_q[$];
    int trunc_cnt = 0;
    int tmo_cnt   = 0;

    always @(posedge clk) begin
        if (m_valid && m_ready) mon_q.push_back({m_last, m_data});
        if (o_trunc)   trunc_cnt <= trunc_cnt + 1;
        if (o_timeout) tmo_cnt   <= tmo_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          s0v; logic [DW-1:0] s0d; logic s0l;
        logic          s1v; logic [DW-1:0] s1d; logic s1l;
        logic          mr;
        logic          ev;  logic [DW-1:0] ed;  logic el;
        logic [1:0]    eo;  logic e0r; logic e1r;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic s0v, input logic [DW-1:0] s0d, input logic s0l,
                                input logic s1v, input logic [DW-1:0] s1d, input logic s1l,
                                input logic mr, input logic ev, input logic [DW-1:0] ed,
                                input logic el, input logic [1:0] eo, input logic e0r,
                                input logic e1r);
        vec_t v;
        v.s0v = s0v; v.s0d = s0d; v.s0l = s0l;
        v.s1v = s1v; v.s1d = s1d; v.s1l = s1l;
        v.mr  = mr;  v.ev  = ev;  v.ed  = ed; v.el = el;
        v.eo  = eo;  v.e0r = e0r; v.e1r = e1r;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int src, input logic v, input logic [DW-1:0] d, input logic l);
        if (src == 0) begin
            s0_valid = v; s0_data = d; s0_last = l;
        end else begin
            s1_valid = v; s1_data = d; s1_last = l;
        end
    endtask

    // Offers n words base..base+n-1; returns right after the edge that accepts the final word.
    task automatic send(input int src, input logic [DW-1:0] base, input int n, input bit last_end);
        int   i      = 0;
        int   budget = 0;
        logic rdy;
        while (i < n) begin
            @(negedge clk);
            drive(src, 1'b1, base + DW'(i), last_end && (i == n - 1));
            #1 rdy = (src == 0) ? s0_ready : s1_ready;
            @(posedge clk);
            if (rdy) i++;
            budget++;
            if (budget > 300) begin
                tests++;
                fails++;
                $display("FAIL send_bound src%0d: accepted %0d words, required %0d", src, i, n);
                return;
            end
        end
    endtask

    task automatic check_stream(input string name);
        check({name, "_count"}, 64'(mon_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < mon_q.size())
                check($sformatf("%s_word%0d", name, i), 64'(mon_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        int tbase, tobase;
        bit early;

        reset_n = 1'b0;
        m_ready = 1'b1;
        drive(0, 1'b0, '0, 1'b0);
        drive(1, 1'b0, '0, 1'b0);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_m_valid",   m_valid,   0);
        check("rst_m_last",    m_last,    0);
        check("rst_m_data",    m_data,    0);
        check("rst_owner",     o_owner,   0);
        check("rst_trunc",     o_trunc,   0);
        check("rst_timeout",   o_timeout, 0);
        check("rst_s0_ready",  s0_ready,  0);
        check("rst_s1_ready",  s1_ready,  0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // s0 4-word packet at full rate, then s1 3-word packet with 5 cycles of back-pressure
        vecs[0]  = mk(1, 32'h10, 0, 0, 0,      0, 1,  0, 0,      0, 2'b00, 0, 0);
        vecs[1]  = mk(1, 32'h10, 0, 0, 0,      0, 1,  0, 0,      0, 2'b01, 1, 0);
        vecs[2]  = mk(1, 32'h11, 0, 0, 0,      0, 1,  1, 32'h10, 0, 2'b01, 1, 0);
        vecs[3]  = mk(1, 32'h12, 0, 0, 0,      0, 1,  1, 32'h11, 0, 2'b01, 1, 0);
        vecs[4]  = mk(1, 32'h13, 1, 0, 0,      0, 1,  1, 32'h12, 0, 2'b01, 1, 0);
        vecs[5]  = mk(0, 0,      0, 0, 0,      0, 1,  1, 32'h13, 1, 2'b00, 0, 0);
        vecs[6]  = mk(0, 0,      0, 1, 32'hA0, 0, 1,  0, 0,      0, 2'b00, 0, 0);
        vecs[7]  = mk(0, 0,      0, 1, 32'hA0, 0, 1,  0, 0,      0, 2'b10, 0, 1);
        vecs[8]  = mk(0, 0,      0, 1, 32'hA1, 0, 0,  1, 32'hA0, 0, 2'b10, 0, 0);
        vecs[9]  = mk(0, 0,      0, 1, 32'hA1, 0, 0,  1, 32'hA0, 0, 2'b10, 0, 0);
        vecs[10] = mk(0, 0,      0, 1, 32'hA1, 0, 0,  1, 32'hA0, 0, 2'b10, 0, 0);
        vecs[11] = mk(0, 0,      0, 1, 32'hA1, 0, 0,  1, 32'hA0, 0, 2'b10, 0, 0);
        vecs[12] = mk(0, 0,      0, 1, 32'hA1, 0, 0,  1, 32'hA0, 0, 2'b10, 0, 0);
        vecs[13] = mk(0, 0,      0, 1, 32'hA1, 0, 1,  1, 32'hA0, 0, 2'b10, 0, 1);
        vecs[14] = mk(0, 0,      0, 1, 32'hA2, 1, 1,  1, 32'hA1, 0, 2'b10, 0, 1);
        vecs[15] = mk(0, 0,      0, 0, 0,      0, 1,  1, 32'hA2, 1, 2'b00, 0, 0);
        vecs[16] = mk(0, 0,      0, 0, 0,      0, 1,  0, 0,      0, 2'b00, 0, 0);

        for (int i = 0; i < 17; i++) begin
            drive(0, vecs[i].s0v, vecs[i].s0d, vecs[i].s0l);
            drive(1, vecs[i].s1v, vecs[i].s1d, vecs[i].s1l);
            m_ready = vecs[i].mr;
            #1;
            check($sformatf("vec%0d_m_valid", i),  m_valid,  vecs[i].ev);
            if (vecs[i].ev)
                check($sformatf("vec%0d_m_data", i), m_data, vecs[i].ed);
            check($sformatf("vec%0d_m_last", i),   m_last,   vecs[i].el);
            check($sformatf("vec%0d_owner", i),    o_owner,  vecs[i].eo);
            check($sformatf("vec%0d_s0_ready", i), s0_ready, vecs[i].e0r);
            check($sformatf("vec%0d_s1_ready", i), s1_ready, vecs[i].e1r);
            @(negedge clk);
        end

        // Both sources hold two 3-word packets each
        mon_q.delete();
        exp_q.delete();
        fork
            begin
                send(0, 32'h100, 3, 1);
                send(0, 32'h110, 3, 1);
                @(negedge clk);
                drive(0, 1'b0, '0, 1'b0);
            end
            begin
                send(1, 32'h200, 3, 1);
                send(1, 32'h210, 3, 1);
                @(negedge clk);
                drive(1, 1'b0, '0, 1'b0);
            end
        join
        repeat (3) @(negedge clk);
`ifdef UPLINK_ARB_STRICT_PRIO_EN
        for (int w = 0; w < 3; w++) exp_q.push_back({(w == 2), 32'h100 + DW'(w)});
        for (int w = 0; w < 3; w++) exp_q.push_back({(w == 2), 32'h110 + DW'(w)});
        for (int w = 0; w < 3; w++) exp_q.push_back({(w == 2), 32'h200 + DW'(w)});
        for (int w = 0; w < 3; w++) exp_q.push_back({(w == 2), 32'h210 + DW'(w)});
`else
        for (int w = 0; w < 3; w++) exp_q.push_back({(w == 2), 32'h100 + DW'(w)});
        for (int w = 0; w < 3; w++) exp_q.push_back({(w == 2), 32'h200 + DW'(w)});
        for (int w = 0; w < 3; w++) exp_q.push_back({(w == 2), 32'h110 + DW'(w)});
        for (int w = 0; w < 3; w++) exp_q.push_back({(w == 2), 32'h210 + DW'(w)});
`endif
        check_stream("arb_order");

        // Length limit: 12-word packet from s1, cut at word 8
        mon_q.delete();
        exp_q.delete();
        tbase = trunc_cnt;
        send(1, 32'h300, 12, 1);
        @(negedge clk);
        drive(1, 1'b0, '0, 1'b0);
        check("trunc_back_idle", o_owner, 2'b00);
        repeat (2) @(negedge clk);
        for (int w = 0; w < MAXW; w++) exp_q.push_back({(w == MAXW - 1), 32'h300 + DW'(w)});
        check_stream("trunc");
        check("trunc_pulses", 64'(trunc_cnt - tbase), 1);

        // Stall abort: 2 words, then valid low for STO cycles
        mon_q.delete();
        exp_q.delete();
        tobase = tmo_cnt;
        send(0, 32'h400, 2, 0);
        @(negedge clk);
        drive(0, 1'b0, '0, 1'b0);
        early = 1'b0;
        for (int c = 1; c < STO; c++) begin
            @(negedge clk);
            if (o_timeout) early = 1'b1;
        end
        check("timeout_early", early, 0);
        @(negedge clk);
        check("timeout_pulse",     o_timeout, 1);
        check("timeout_owner",     o_owner,   2'b01);
        check("timeout_drain_rdy", s0_ready,  1);
        @(negedge clk);
        check("timeout_one_cycle", o_timeout, 0);
        fork
            begin
                send(0, 32'h410, 3, 1);
                @(negedge clk);
                drive(0, 1'b0, '0, 1'b0);
            end
            begin
                send(1, 32'h500, 2, 1);
                @(negedge clk);
                drive(1, 1'b0, '0, 1'b0);
            end
        join
        repeat (3) @(negedge clk);
        exp_q.push_back({1'b0, 32'h400});
        exp_q.push_back({1'b0, 32'h401});
        exp_q.push_back({1'b0, 32'h500});
        exp_q.push_back({1'b1, 32'h501});
        check_stream("timeout");
        check("timeout_pulses", 64'(tmo_cnt - tobase), 1);

        // Valid returns on the cycle the stall counter would expire: packet completes normally
        mon_q.delete();
        exp_q.delete();
        tobase = tmo_cnt;
        send(0, 32'h800, 2, 0);
        @(negedge clk);
        drive(0, 1'b0, '0, 1'b0);
        repeat (STO - 2) @(negedge clk);
        send(0, 32'h802, 1, 1);
        @(negedge clk);
        drive(0, 1'b0, '0, 1'b0);
        check("valid_wins_idle", o_owner, 2'b00);
        repeat (2) @(negedge clk);
        exp_q.push_back({1'b0, 32'h800});
        exp_q.push_back({1'b0, 32'h801});
        exp_q.push_back({1'b1, 32'h802});
        check_stream("valid_wins");
        check("valid_wins_no_timeout", 64'(tmo_cnt - tobase), 0);

        // Reset mid-packet with a word in the output register
        @(negedge clk);
        drive(0, 1'b1, 32'h600, 1'b0);
        repeat (4) @(negedge clk);
        #1 check("pre_reset_m_valid", m_valid, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_m_last",  m_last,  0);
        check("mid_rst_owner",   o_owner, 2'b00);
        check("mid_rst_s0_rdy",  s0_ready, 0);
        drive(0, 1'b0, '0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_owner", o_owner, 2'b00);
        mon_q.delete();
        exp_q.delete();
        tbase = trunc_cnt;
        send(0, 32'h700, MAXW, 1);
        @(negedge clk);
        drive(0, 1'b0, '0, 1'b0);
        repeat (3) @(negedge clk);
        for (int w = 0; w < MAXW; w++) exp_q.push_back({(w == MAXW - 1), 32'h700 + DW'(w)});
        check_stream("post_rst");
        check("post_rst_no_trunc", 64'(trunc_cnt - tbase), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
